alu_sequencer: RTL and testbench

Command sequencer that sits directly upstream of the 16-bit ALU breadboard and drives its `A` and `opcode` inputs. It holds a small program of (opcode, operand) words, steps through it one instruction at a time, and drives NO-OP between instructions so the ALU accumulator holds. It watches the ALU `error` bus and halts with a fault record on overflow or divide-by-zero.

---
 rtl/alu_sequencer_if.sv | 32 +++
 rtl/alu_sequencer.sv | 155 +++++++++++++++
 tb/tb_alu_sequencer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Host/ALU-facing bus of the ALU command sequencer: program load, start,
// the instruction stream into the ALU and the status/fault record back out.
interface alu_sequencer_if #(
  parameter int ADDR_W = 4
);
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [19:0]       load_data;
  logic              start;
  logic [1:0]        error;

  logic [15:0]       A;
  logic [3:0]        opcode;
  logic              issue;
  logic              busy;
  logic              done;
  logic              fault;
  logic [ADDR_W-1:0] fault_pc;
  logic [1:0]        fault_code;

  // Host side: loads the program, starts it and plays the ALU error bus.
  modport master (
    output load_en, load_addr, load_data, start, error,
    input  A, opcode, issue, busy, done, fault, fault_pc, fault_code
  );

  // Sequencer side.
  modport slave (
    input  load_en, load_addr, load_data, start, error,
    output A, opcode, issue, busy, done, fault, fault_pc, fault_code
  );
endinterface

// File: rtl/alu_sequencer.sv
// Steps a small (opcode, operand) program into the 16-bit ALU, one instruction
// per FETCH/ISSUE pair, with NO-OP in between; halts with a fault record on ALU error.
module alu_sequencer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input logic           clk,
  input logic           rst,
  alu_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    DONE,
    FAULT
  } state_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] operand;
  } progWord_t;

  localparam logic [3:0]        OpNop  = 4'b0000;
  localparam logic [3:0]        OpHalt = 4'b0011;
  localparam logic [ADDR_W-1:0] LastPc = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  progWord_t         progMem [DEPTH];
  progWord_t         fetchWord;

  logic [15:0]       aReg;
  logic [3:0]        opReg;
  logic              issueReg;
  logic              busyReg;
  logic              doneReg;
  logic              faultReg;
  logic [ADDR_W-1:0] faultPcReg;
  logic [1:0]        faultCodeReg;

  logic              hostWindow;
  logic              memWe;

  // Host requests are only honoured while no program is running.
  assign hostWindow = (state == IDLE) || (state == DONE) || (state == FAULT);
  assign memWe      = hostWindow && bus.load_en;
  assign fetchWord  = progMem[pc];

  // NOTE: the program RAM has no reset on purpose; a loaded program must survive
  // rst, and leaving it out keeps the array mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (memWe) begin
      progMem[bus.load_addr] <= progWord_t'(bus.load_data);
    end
  end

  // NOTE: every register below is written with <= so all of them see the
  // pre-edge values of state/pc, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pc           <= '0;
      aReg         <= '0;
      opReg        <= OpNop;
      issueReg     <= 1'b0;
      busyReg      <= 1'b0;
      doneReg      <= 1'b0;
      faultReg     <= 1'b0;
      faultPcReg   <= '0;
      faultCodeReg <= '0;
    end else begin
      case (state)
        IDLE, DONE, FAULT: begin
          aReg     <= '0;
          opReg    <= OpNop;
          issueReg <= 1'b0;
          // A simultaneous load wins; the start is dropped.
          if (bus.start && !bus.load_en) begin
            state        <= FETCH;
            pc           <= '0;
            busyReg      <= 1'b1;
            doneReg      <= 1'b0;
            faultReg     <= 1'b0;
            faultPcReg   <= '0;
            faultCodeReg <= '0;
          end
        end

        FETCH: begin
          if (fetchWord.op == OpHalt) begin
            state   <= DONE;
            busyReg <= 1'b0;
            doneReg <= 1'b1;
          end else begin
            state    <= ISSUE;
            opReg    <= fetchWord.op;
            aReg     <= fetchWord.operand;
            issueReg <= 1'b1;
          end
        end

        ISSUE: begin
          // The ALU captured this instruction at this edge; back to NO-OP so it holds.
          opReg    <= OpNop;
          aReg     <= '0;
          issueReg <= 1'b0;
          if (bus.error != 2'b00) begin
            state        <= FAULT;
            busyReg      <= 1'b0;
            faultReg     <= 1'b1;
            faultPcReg   <= pc;
            faultCodeReg <= bus.error;
          end else if (pc == LastPc) begin
            state   <= DONE;
            busyReg <= 1'b0;
            doneReg <= 1'b1;
          end else begin
            state <= FETCH;
            pc    <= pc + ADDR_W'(1);
          end
        end

        default: begin
          state    <= IDLE;
          busyReg  <= 1'b0;
          issueReg <= 1'b0;
          opReg    <= OpNop;
          aReg     <= '0;
        end
      endcase
    end
  end

  assign bus.A          = aReg;
  assign bus.opcode     = opReg;
  assign bus.issue      = issueReg;
  assign bus.busy       = busyReg;
  assign bus.done       = doneReg;
  assign bus.fault      = faultReg;
  assign bus.fault_pc   = faultPcReg;
  assign bus.fault_code = faultCodeReg;

  // HALT is a sequencer directive and must never reach the ALU.
  haltNeverIssued: assert property (@(posedge clk) disable iff (rst)
    issueReg |-> (opReg != OpHalt));

  busyTracksState: assert property (@(posedge clk)
    busyReg == ((state == FETCH) || (state == ISSUE)));

  doneFaultExclusive: assert property (@(posedge clk)
    !(doneReg && faultReg));

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: drives program loads/starts, models the
// ALU error bus, and checks every cycle of each run against hand-built tables.
module tb_alu_sequencer;

  localparam logic [3:0] OpNop    = 4'h0;
  localparam logic [3:0] OpReset  = 4'h1;
  localparam logic [3:0] OpHalt   = 4'h3;
  localparam logic [3:0] OpAdd    = 4'h4;
  localparam logic [3:0] OpDiv    = 4'h6;
  localparam logic [3:0] OpAnd    = 4'h9;
  localparam logic [3:0] OpXyz    = 4'h5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_sequencer_if #(.ADDR_W(4)) bus();

  alu_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ALU error model: divide-by-zero on DIV/0, overflow on ADD of 0x7FFF.
  always_comb begin
    bus.error = 2'b00;
    if (bus.issue && bus.opcode == OpDiv && bus.A == 16'h0000) bus.error = 2'b10;
    if (bus.issue && bus.opcode == OpAdd && bus.A == 16'h7FFF) bus.error = 2'b01;
  end

  int checks   = 0;
  int failures = 0;

  logic [3:0]  expOp [16];
  logic [15:0] expA  [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic loadWord(input logic [3:0] addr, input logic [3:0] op, input logic [15:0] val);
    bus.load_en   = 1'b1;
    bus.load_addr = addr;
    bus.load_data = {op, val};
    tick();
    bus.load_en   = 1'b0;
  endtask

  // Honoured load: updates memory and the expected-instruction table.
  task automatic prog(input logic [3:0] addr, input logic [3:0] op, input logic [15:0] val);
    loadWord(addr, op, val);
    expOp[addr] = op;
    expA[addr]  = val;
  endtask

  // Cycle c counts from 1 = first cycle after the start edge. K instructions;
  // halted: HALT follows them, done visible at c=2K+2, else done at c=2K+1.
  task automatic checkCycle(input string tag, input int c, input int k, input bit halted);
    int  last;
    bit  isIssue;
    logic [3:0]  eOp;
    logic [15:0] eA;
    last    = halted ? 2*k + 2 : 2*k + 1;
    isIssue = (c % 2 == 0) && (c <= 2*k);
    eOp = OpNop;
    eA  = 16'h0;
    if (isIssue) begin
      eOp = expOp[c/2 - 1];
      eA  = expA[c/2 - 1];
    end
    check($sformatf("%s_c%0d_issue", tag, c), 32'(bus.issue), 32'(isIssue));
    check($sformatf("%s_c%0d_opcode", tag, c), 32'(bus.opcode), 32'(eOp));
    check($sformatf("%s_c%0d_A", tag, c), 32'(bus.A), 32'(eA));
    check($sformatf("%s_c%0d_busy", tag, c), 32'(bus.busy), 32'(c < last));
    if (!(halted && c == last - 1))
      check($sformatf("%s_c%0d_done", tag, c), 32'(bus.done), 32'(c == last));
    check($sformatf("%s_c%0d_fault", tag, c), 32'(bus.fault), 32'h0);
  endtask

  task automatic pulseStart();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic runProgram(input string tag, input int k, input bit halted);
    int last;
    last = halted ? 2*k + 2 : 2*k + 1;
    pulseStart();
    check({tag, "_fault_pc_cleared"}, 32'(bus.fault_pc), 32'h0);
    check({tag, "_fault_code_cleared"}, 32'(bus.fault_code), 32'h0);
    for (int c = 1; c <= last; c++) begin
      checkCycle(tag, c, k, halted);
      if (c < last) tick();
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    check({tag, "_A"}, 32'(bus.A), 32'h0);
    check({tag, "_opcode"}, 32'(bus.opcode), 32'h0);
    check({tag, "_issue"}, 32'(bus.issue), 32'h0);
    check({tag, "_busy"}, 32'(bus.busy), 32'h0);
    check({tag, "_done"}, 32'(bus.done), 32'h0);
    check({tag, "_fault"}, 32'(bus.fault), 32'h0);
    check({tag, "_fault_pc"}, 32'(bus.fault_pc), 32'h0);
    check({tag, "_fault_code"}, 32'(bus.fault_code), 32'h0);
  endtask

  initial begin
    int issues;

    bus.load_en   = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;
    bus.start     = 1'b0;
    for (int i = 0; i < 16; i++) begin
      expOp[i] = OpNop;
      expA[i]  = 16'h0;
    end

    rst = 1'b1;
    tick();
    tick();
    checkIdleOutputs("reset");
    rst = 1'b0;
    tick();

    // Basic program: RESET/0, ADD/12, AND/0xF, HALT.
    prog(4'd0, OpReset, 16'd0);
    prog(4'd1, OpAdd, 16'd12);
    prog(4'd2, OpAnd, 16'h000F);
    prog(4'd3, OpHalt, 16'd0);
    runProgram("basic", 3, 1'b1);

    // Divide-by-zero at address 1: fault on the edge ending c=4.
    prog(4'd1, OpDiv, 16'd0);
    prog(4'd2, OpAdd, 16'd1);
    pulseStart();
    issues = 0;
    for (int c = 1; c <= 10; c++) begin
      if (bus.issue) issues++;
      check($sformatf("div_c%0d_fault", c), 32'(bus.fault), 32'(c >= 5));
      if (c == 4) check("div_c4_opcode", 32'(bus.opcode), 32'(OpDiv));
      if (c >= 5) check($sformatf("div_c%0d_opcode", c), 32'(bus.opcode), 32'h0);
      if (c == 5) begin
        check("div_fault_pc", 32'(bus.fault_pc), 32'd1);
        check("div_fault_code", 32'(bus.fault_code), 32'h2);
        check("div_busy", 32'(bus.busy), 32'h0);
        check("div_done", 32'(bus.done), 32'h0);
      end
      tick();
    end
    check("div_issue_count", 32'(issues), 32'd2);

    // Overflow at address 2.
    prog(4'd1, OpAdd, 16'd1);
    prog(4'd2, OpAdd, 16'h7FFF);
    pulseStart();
    for (int c = 1; c < 7; c++) begin
      check($sformatf("ovf_c%0d_fault", c), 32'(bus.fault), 32'h0);
      tick();
    end
    check("ovf_fault", 32'(bus.fault), 32'h1);
    check("ovf_fault_pc", 32'(bus.fault_pc), 32'd2);
    check("ovf_fault_code", 32'(bus.fault_code), 32'h1);

    // Full 16-word program without HALT; must not wrap.
    for (int i = 0; i < 16; i++) prog(4'(i), OpAdd, 16'd1);
    runProgram("full", 16, 1'b0);
    issues = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus.issue) issues++;
    end
    check("full_no_wrap_issues", 32'(issues), 32'd0);
    check("full_done_sticky", 32'(bus.done), 32'h1);

    // Requests during ISSUE of instruction 0 are ignored.
    prog(4'd0, OpReset, 16'd0);
    prog(4'd1, OpAdd, 16'd12);
    prog(4'd2, OpAnd, 16'h000F);
    prog(4'd3, OpHalt, 16'd0);
    pulseStart();
    checkCycle("busyreq", 1, 3, 1'b1);
    tick();
    checkCycle("busyreq", 2, 3, 1'b1);
    bus.start     = 1'b1;
    bus.load_en   = 1'b1;
    bus.load_addr = 4'd2;
    bus.load_data = {OpHalt, 16'd0};
    tick();
    bus.start   = 1'b0;
    bus.load_en = 1'b0;
    for (int c = 3; c <= 8; c++) begin
      checkCycle("busyreq", c, 3, 1'b1);
      if (c < 8) tick();
    end

    // start + load_en together in DONE: load only.
    bus.start     = 1'b1;
    bus.load_en   = 1'b1;
    bus.load_addr = 4'd2;
    bus.load_data = {OpXyz, 16'h00AA};
    tick();
    bus.start   = 1'b0;
    bus.load_en = 1'b0;
    expOp[2] = OpXyz;
    expA[2]  = 16'h00AA;
    check("startload_done", 32'(bus.done), 32'h1);
    check("startload_busy", 32'(bus.busy), 32'h0);
    tick();
    check("startload_busy2", 32'(bus.busy), 32'h0);
    check("startload_issue2", 32'(bus.issue), 32'h0);
    runProgram("rerun", 3, 1'b1);

    // Reset during ISSUE of instruction 2 (c=6).
    pulseStart();
    for (int c = 1; c <= 6; c++) begin
      checkCycle("midrst", c, 3, 1'b1);
      if (c < 6) tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkIdleOutputs("midrst_after");
    tick();
    check("midrst_idle_busy", 32'(bus.busy), 32'h0);
    check("midrst_idle_issue", 32'(bus.issue), 32'h0);
    runProgram("after_rst", 3, 1'b1);

    // HALT at address 0: done with no issue.
    prog(4'd0, OpHalt, 16'd0);
    runProgram("halt0", 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
